lsu_mem_port: RTL

//  CPU-side load/store initiator for the byte-lane data RAM port (addr/data/mask/we
//  in, registered read data and stall out). Accepts one load/store per request from
//  the execute stage, drives the RAM port, de-rotates and sign/zero-extends load data,
//  and returns one completion pulse. Unaligned accesses are passed through; the RAM

---
 rtl/lsu_mem_port.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_port.sv
// Load/store initiator: latches one request, drives the byte-lane RAM port, aligns/extends load data.
// Latency I_req->O_done: load 3 cycles (+1 per stalled CAPTURE cycle), store 2, bad funct3 1.
// Backpressure: I_mem_stall holds a load in CAPTURE (timeout -> O_err); requests while busy are dropped.
module lsu_mem_port #(
   parameter int TIMEOUT = 16
) (
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic        I_req,
   input  logic        I_we,
   input  logic [2:0]  I_funct3,
   input  logic [31:0] I_addr,
   input  logic [31:0] I_wdata,
   output logic        O_busy,
   output logic        O_done,
   output logic        O_err,
   output logic [31:0] O_rdata,
   output logic [31:0] O_mem_addr,
   output logic [31:0] O_mem_data,
   output logic [3:0]  O_mem_mask,
   output logic        O_mem_we,
   input  logic [31:0] I_mem_rdata,
   input  logic        I_mem_stall
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_CAPTURE,
      S_RESP
   } state_t;

   state_t         state_q, state_d;
   logic           we_q;
   logic [2:0]     funct3_q;
   logic [31:0]    addr_q;
   logic [31:0]    wdata_q;
   logic [31:0]    rdata_q;
   logic           err_q;
   logic [CW-1:0]  cnt_q;

   logic           bad_in;
   logic           cnt_hit;
   logic [3:0]     mask_w;
   logic [31:0]    rot;
   logic [31:0]    load_val;

   // Decode request legality, byte mask, lane rotation and extension of load data.
   always_comb begin
      bad_in   = 1'b0;
      mask_w   = 4'b1111;
      rot      = I_mem_rdata;
      load_val = 32'h0;
      cnt_hit  = (cnt_q == CW'(TIMEOUT - 1));

      // Stores only have B/H/W; loads additionally have BU/HU.
      if (I_we) begin
         bad_in = (I_funct3 > 3'd2);
      end else begin
         bad_in = (I_funct3 == 3'd3) || (I_funct3 == 3'd6) || (I_funct3 == 3'd7);
      end

      case (funct3_q[1:0])
         2'd0:    mask_w = 4'b0001;
         2'd1:    mask_w = 4'b0011;
         default: mask_w = 4'b1111;
      endcase

      // RAM returns physical lanes; bring the byte at addr down to bits 7:0.
      case (addr_q[1:0])
         2'd0:    rot = I_mem_rdata;
         2'd1:    rot = {I_mem_rdata[7:0],  I_mem_rdata[31:8]};
         2'd2:    rot = {I_mem_rdata[15:0], I_mem_rdata[31:16]};
         default: rot = {I_mem_rdata[23:0], I_mem_rdata[31:24]};
      endcase

      // funct3[2] selects zero extension (BU/HU).
      case (funct3_q[1:0])
         2'd0:    load_val = {{24{~funct3_q[2] & rot[7]}},  rot[7:0]};
         2'd1:    load_val = {{16{~funct3_q[2] & rot[15]}}, rot[15:0]};
         default: load_val = rot;
      endcase
   end

   // Next-state and port outputs; everything idles at zero outside its own state.
   always_comb begin
      state_d    = state_q;
      O_busy     = 1'b1;
      O_done     = 1'b0;
      O_err      = 1'b0;
      O_rdata    = rdata_q;
      O_mem_addr = 32'h0;
      O_mem_data = 32'h0;
      O_mem_mask = 4'b0000;
      O_mem_we   = 1'b0;

      case (state_q)
         S_IDLE: begin
            O_busy = 1'b0;
            if (I_req) begin
               state_d = bad_in ? S_RESP : S_ISSUE;
            end
         end
         S_ISSUE: begin
            O_mem_addr = addr_q;
            if (we_q) begin
               O_mem_we   = 1'b1;
               O_mem_mask = mask_w;
               O_mem_data = wdata_q;
               state_d    = S_RESP;
            end else begin
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            O_mem_addr = addr_q;
            if (!I_mem_stall || cnt_hit) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            O_done  = 1'b1;
            O_err   = err_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge I_clk) begin
      if (!I_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Request latch, stall counter, error flag and held load result.
   always_ff @(posedge I_clk) begin
      if (!I_rst) begin
         we_q     <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         rdata_q  <= 32'h0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (I_req) begin
                  we_q     <= I_we;
                  funct3_q <= I_funct3;
                  addr_q   <= I_addr;
                  wdata_q  <= I_wdata;
                  err_q    <= bad_in;
                  cnt_q    <= '0;
               end
            end
            S_CAPTURE: begin
               if (!I_mem_stall) begin
                  rdata_q <= load_val;
               end else if (cnt_hit) begin
                  err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
